// File: rtl/fetch_pc_sequencer.sv
// IF-stage PC owner: picks next PC, fetches from imem into IF/ID,
// skids one instruction under stall and squashes wrong-path fetches.
//
// Ports:
//   clk, reset            clock, async active-low reset
//   inStall               ID cannot take a new instruction
//   inBranchTaken/Target  EX-stage taken branch and its target
//   inJr/inJrTarget       ID-stage register jump and its target
//   inJump/inJumpIndex    ID-stage J/JAL and its 26-bit index
//   outImemReq/Addr       fetch request and address
//   inImemAck/Data        fetch return handshake and instruction
//   outInstr/PostPc/Valid IF/ID register contents
//   outFlushID            one-cycle pulse per redirect
module fetch_pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inStall,
    input  logic        inBranchTaken,
    input  logic [31:0] inBranchTarget,
    input  logic        inJr,
    input  logic [31:0] inJrTarget,
    input  logic        inJump,
    input  logic [25:0] inJumpIndex,
    output logic        outImemReq,
    output logic [31:0] outImemAddr,
    input  logic        inImemAck,
    input  logic [31:0] inImemData,
    output logic [31:0] outInstr,
    output logic [31:0] outPostPc,
    output logic        outValid,
    output logic        outFlushID
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_SKID = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic        r_pending;
    logic [31:0] r_pendTarget;
    logic [31:0] r_skidInstr;
    logic [31:0] r_skidPc;
    logic [31:0] r_instr;
    logic [31:0] r_postPc;
    logic        r_valid;
    logic        r_flush;

    logic        w_redirect;
    logic [31:0] w_target;
    logic [31:0] w_pcInc;
    logic        w_slotFree;
    logic        w_unused_bits;

    assign w_redirect = inBranchTaken | inJr | inJump;
    assign w_pcInc    = r_pc + 32'd4;
    // IF/ID can take new data if empty or being consumed this cycle
    assign w_slotFree = !r_valid || !inStall;
    // Low target bits are forced to 00, so the raw ones are dropped
    assign w_unused_bits = ^{inBranchTarget[1:0], inJrTarget[1:0]};

    // Priority: branch > jr > jump
    always_comb begin
        w_target = {r_postPc[31:28], inJumpIndex, 2'b00};
        if (inBranchTaken)
            w_target = {inBranchTarget[31:2], 2'b00};
        else if (inJr)
            w_target = {inJrTarget[31:2], 2'b00};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_pending    <= 1'b0;
            r_pendTarget <= 32'd0;
            r_skidInstr  <= 32'd0;
            r_skidPc     <= 32'd0;
            r_instr      <= 32'd0;
            r_postPc     <= 32'd0;
            r_valid      <= 1'b0;
            r_flush      <= 1'b0;
        end else begin
            r_flush <= w_redirect;
            unique case (r_state)
                S_IDLE: begin
                    r_state <= S_REQ;
                    r_valid <= 1'b0;
                    if (w_redirect)
                        r_pc <= w_target;
                end
                S_REQ: begin
                    if (inImemAck) begin
                        if (w_redirect) begin
                            // wrong-path data: go straight to target
                            r_pc      <= w_target;
                            r_pending <= 1'b0;
                            r_valid   <= 1'b0;
                        end else if (r_pending) begin
                            // ack belongs to the pre-redirect address
                            r_pc      <= r_pendTarget;
                            r_pending <= 1'b0;
                            r_valid   <= r_valid && inStall;
                        end else if (w_slotFree) begin
                            r_instr  <= inImemData;
                            r_postPc <= w_pcInc;
                            r_valid  <= 1'b1;
                            r_pc     <= w_pcInc;
                        end else begin
                            r_skidInstr <= inImemData;
                            r_skidPc    <= w_pcInc;
                            r_pc        <= w_pcInc;
                            r_state     <= S_SKID;
                        end
                    end else if (w_redirect) begin
                        // address must stay stable until ack
                        r_pending    <= 1'b1;
                        r_pendTarget <= w_target;
                        r_valid      <= 1'b0;
                    end else begin
                        r_valid <= r_valid && inStall;
                    end
                end
                S_SKID: begin
                    if (w_redirect) begin
                        r_pc    <= w_target;
                        r_valid <= 1'b0;
                        r_state <= S_REQ;
                    end else if (!inStall) begin
                        r_instr  <= r_skidInstr;
                        r_postPc <= r_skidPc;
                        r_valid  <= 1'b1;
                        r_state  <= S_REQ;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign outImemReq  = (r_state == S_REQ);
    assign outImemAddr = r_pc;
    assign outInstr    = r_instr;
    assign outPostPc   = r_postPc;
    assign outValid    = r_valid;
    assign outFlushID  = r_flush;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed bench for fetch_pc_sequencer.
// Memory returns addr + 0x1000_0000 as the instruction word.
module tb_fetch_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        inStall;
    logic        inBranchTaken;
    logic [31:0] inBranchTarget;
    logic        inJr;
    logic [31:0] inJrTarget;
    logic        inJump;
    logic [25:0] inJumpIndex;
    logic        outImemReq;
    logic [31:0] outImemAddr;
    logic        inImemAck;
    logic [31:0] inImemData;
    logic [31:0] outInstr;
    logic [31:0] outPostPc;
    logic        outValid;
    logic        outFlushID;

    int n_chk;
    int n_fail;

    fetch_pc_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .inStall        (inStall),
        .inBranchTaken  (inBranchTaken),
        .inBranchTarget (inBranchTarget),
        .inJr           (inJr),
        .inJrTarget     (inJrTarget),
        .inJump         (inJump),
        .inJumpIndex    (inJumpIndex),
        .outImemReq     (outImemReq),
        .outImemAddr    (outImemAddr),
        .inImemAck      (inImemAck),
        .inImemData     (inImemData),
        .outInstr       (outInstr),
        .outPostPc      (outPostPc),
        .outValid       (outValid),
        .outFlushID     (outFlushID)
    );

    assign inImemData = outImemAddr + 32'h1000_0000;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag,
                            input logic [31:0] obs,
                            input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ack, input logic stall);
        inImemAck = ack;
        inStall   = stall;
        inBranchTaken = 1'b0;
        inJr   = 1'b0;
        inJump = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        reset = 1'b1;
        drive(1'b0, 1'b0);
        inBranchTarget = 32'd0;
        inJrTarget = 32'd0;
        inJumpIndex = 26'd0;
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_req", {31'd0, outImemReq}, 32'd0);
        check_eq("rst_addr", outImemAddr, 32'h0);
        check_eq("rst_instr", outInstr, 32'h0);
        check_eq("rst_ppc", outPostPc, 32'h0);
        check_eq("rst_valid", {31'd0, outValid}, 32'd0);
        check_eq("rst_flush", {31'd0, outFlushID}, 32'd0);

        reset = 1'b1;
        drive(1'b1, 1'b0);
        step();
        check_eq("first_req", {31'd0, outImemReq}, 32'd1);
        check_eq("first_addr", outImemAddr, 32'h0);
        check_eq("first_valid", {31'd0, outValid}, 32'd0);
        step();
        check_eq("seq_addr4", outImemAddr, 32'h4);
        check_eq("seq_ppc4", outPostPc, 32'h4);
        check_eq("seq_instr0", outInstr, 32'h1000_0000);
        check_eq("seq_valid", {31'd0, outValid}, 32'd1);
        step();
        check_eq("seq_addr8", outImemAddr, 32'h8);
        check_eq("seq_ppc8", outPostPc, 32'h8);
        step();
        check_eq("seq_ppcC", outPostPc, 32'hC);
        step();
        check_eq("seq_addr10", outImemAddr, 32'h10);
        check_eq("seq_instrC", outInstr, 32'h1000_000C);

        // ack for 0x10 under stall with full slot -> skid
        drive(1'b1, 1'b1);
        step();
        check_eq("skid_req", {31'd0, outImemReq}, 32'd0);
        check_eq("skid_addr", outImemAddr, 32'h14);
        check_eq("skid_ppc_hold", outPostPc, 32'h10);
        drive(1'b0, 1'b1);
        step();
        check_eq("skid_hold_req", {31'd0, outImemReq}, 32'd0);
        drive(1'b0, 1'b0);
        step();
        check_eq("unskid_ppc", outPostPc, 32'h14);
        check_eq("unskid_instr", outInstr, 32'h1000_0010);
        check_eq("unskid_valid", {31'd0, outValid}, 32'd1);
        check_eq("unskid_req", {31'd0, outImemReq}, 32'd1);
        check_eq("unskid_addr", outImemAddr, 32'h14);

        // branch with ack: low bits forced, data discarded
        drive(1'b1, 1'b0);
        inBranchTaken = 1'b1;
        inBranchTarget = 32'h4000_0007;
        step();
        check_eq("br_addr", outImemAddr, 32'h4000_0004);
        check_eq("br_valid", {31'd0, outValid}, 32'd0);
        check_eq("br_flush", {31'd0, outFlushID}, 32'd1);
        drive(1'b1, 1'b0);
        step();
        check_eq("br_ppc", outPostPc, 32'h4000_0008);
        check_eq("br_flush_off", {31'd0, outFlushID}, 32'd0);

        // J-type target from upper PC+4 nibble
        drive(1'b1, 1'b0);
        inJump = 1'b1;
        inJumpIndex = 26'h0000100;
        step();
        check_eq("j_addr", outImemAddr, 32'h4000_0400);
        check_eq("j_flush", {31'd0, outFlushID}, 32'd1);
        drive(1'b0, 1'b0);
        step();
        check_eq("j_flush_once", {31'd0, outFlushID}, 32'd0);
        check_eq("j_valid", {31'd0, outValid}, 32'd0);

        // branch beats jump
        drive(1'b1, 1'b0);
        inBranchTaken = 1'b1;
        inBranchTarget = 32'h200;
        inJump = 1'b1;
        step();
        check_eq("prio_br_addr", outImemAddr, 32'h200);
        // jr beats jump, no ack: pending, consecutive flush
        drive(1'b0, 1'b0);
        inJr = 1'b1;
        inJrTarget = 32'h302;
        inJump = 1'b1;
        step();
        check_eq("jr_pend_addr", outImemAddr, 32'h200);
        check_eq("jr_flush2", {31'd0, outFlushID}, 32'd1);
        drive(1'b1, 1'b0);
        step();
        check_eq("jr_addr", outImemAddr, 32'h300);
        check_eq("jr_valid", {31'd0, outValid}, 32'd0);
        check_eq("jr_flush_off", {31'd0, outFlushID}, 32'd0);

        // redirect to 0x80 while ack for 0x20 outstanding
        drive(1'b1, 1'b0);
        inBranchTaken = 1'b1;
        inBranchTarget = 32'h20;
        step();
        check_eq("to20_addr", outImemAddr, 32'h20);
        drive(1'b0, 1'b0);
        inBranchTaken = 1'b1;
        inBranchTarget = 32'h80;
        step();
        check_eq("pend_addr_a", outImemAddr, 32'h20);
        drive(1'b0, 1'b0);
        step();
        check_eq("pend_addr_b", outImemAddr, 32'h20);
        step();
        check_eq("pend_req", {31'd0, outImemReq}, 32'd1);
        drive(1'b1, 1'b0);
        step();
        check_eq("pend_addr80", outImemAddr, 32'h80);
        check_eq("pend_valid", {31'd0, outValid}, 32'd0);
        step();
        check_eq("after80_ppc", outPostPc, 32'h84);
        check_eq("after80_instr", outInstr, 32'h1000_0080);
        check_eq("after80_valid", {31'd0, outValid}, 32'd1);

        // consumption with no new data
        drive(1'b0, 1'b0);
        step();
        check_eq("consume_valid", {31'd0, outValid}, 32'd0);
        drive(1'b1, 1'b0);
        step();
        check_eq("refill_ppc", outPostPc, 32'h88);
        drive(1'b1, 1'b1);
        step();
        check_eq("skid2_req", {31'd0, outImemReq}, 32'd0);
        check_eq("skid2_addr", outImemAddr, 32'h8C);

        // async reset in S_SKID
        #2 reset = 1'b0;
        #1;
        check_eq("mrst_req", {31'd0, outImemReq}, 32'd0);
        check_eq("mrst_addr", outImemAddr, 32'h0);
        check_eq("mrst_instr", outInstr, 32'h0);
        check_eq("mrst_ppc", outPostPc, 32'h0);
        check_eq("mrst_valid", {31'd0, outValid}, 32'd0);
        check_eq("mrst_flush", {31'd0, outFlushID}, 32'd0);
        step();
        reset = 1'b1;
        drive(1'b1, 1'b0);
        step();
        check_eq("rel_req", {31'd0, outImemReq}, 32'd1);
        check_eq("rel_addr", outImemAddr, 32'h0);
        step();
        check_eq("rel_instr", outInstr, 32'h1000_0000);
        check_eq("rel_ppc", outPostPc, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
